// File: rtl/seq_det_arbiter.sv
// Round-robin shared 1001 detector over 4 channels, one bit per cycle; optional hit counters with SEQ_ARB_CNT_EN.
// Grant is combinational; det_valid is registered one cycle after the consuming edge. Requesters hold until granted.
module seq_det_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       req,
  input  logic [3:0]       bit_in,
  input  logic [3:0]       flush,
  output logic [3:0]       grant,
  output logic             det_valid,
  output logic [1:0]       det_chan
`ifdef SEQ_ARB_CNT_EN
  ,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_rd
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_1    = 2'd1,
    S_10   = 2'd2,
    S_100  = 2'd3
  } ctx_e;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  ctx_e       ctx_q [4];
  ctx_e       ctx_d [4];
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic       det_valid_q, det_valid_d;
  logic [1:0] det_chan_q, det_chan_d;

  logic [3:0] elig;
  logic [1:0] cand;
  logic       gnt_any;
  logic [1:0] gnt_idx;
  ctx_e       eng_cur, eng_nxt;
  logic       eng_bit, eng_hit;
  logic       hit_vld;

  assign elig = req & ~flush;

  // Scan farthest-to-nearest from the pointer so the nearest eligible channel wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_ptr_q;
    cand    = rr_ptr_q;
    for (int k = 4; k >= 1; k--) begin
      cand = rr_ptr_q + 2'(k);
      if (elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign grant = (rstn && gnt_any) ? (4'b0001 << gnt_idx) : 4'b0000;

  // Shared detection engine operating on the granted channel's context.
  always_comb begin
    eng_cur = ctx_q[gnt_idx];
    eng_bit = bit_in[gnt_idx];
    eng_nxt = S_IDLE;
    eng_hit = 1'b0;
    case (eng_cur)
      S_IDLE:  eng_nxt = eng_bit ? S_1 : S_IDLE;
      S_1:     eng_nxt = eng_bit ? S_1 : S_10;
      S_10:    eng_nxt = eng_bit ? S_1 : S_100;
      S_100: begin
        eng_nxt = S_IDLE;
        eng_hit = eng_bit;
      end
      default: eng_nxt = S_IDLE;
    endcase
  end

  assign hit_vld = gnt_any & eng_hit;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    det_valid_d = 1'b0;
    det_chan_d  = det_chan_q;
    for (int i = 0; i < 4; i++) begin
      ctx_d[i] = ctx_q[i];
      if (flush[i]) begin
        ctx_d[i] = S_IDLE;
      end else if (gnt_any && (gnt_idx == 2'(i))) begin
        ctx_d[i] = eng_nxt;
      end
    end
    if (gnt_any) begin
      rr_ptr_d = gnt_idx;
    end
    if (hit_vld) begin
      det_valid_d = 1'b1;
      det_chan_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        ctx_q[i] <= S_IDLE;
      end
      rr_ptr_q    <= 2'd3;
      det_valid_q <= 1'b0;
      det_chan_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        ctx_q[i] <= ctx_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      det_valid_q <= det_valid_d;
      det_chan_q  <= det_chan_d;
    end
  end

  assign det_valid = det_valid_q;
  assign det_chan  = det_chan_q;

`ifdef SEQ_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Saturating per-channel hit counters; flush wins (it also masks the grant).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush[i]) begin
        cnt_d[i] = '0;
      end else if (hit_vld && (gnt_idx == 2'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign cnt_rd = cnt_q[cnt_sel];
`endif

endmodule
